ex_muldiv: RTL and testbench
============================

# ex_muldiv

Multi-cycle multiply/divide unit with architectural HI/LO registers, attached beside the EX-stage ALU of the five-stage MIPS pipeline. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation per instruction and raises a pipeline stall request until the result is ready. It writes HI/LO on completion. Operand width is parametrised, and the iterative divider can be compiled out.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 4 and even.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  EX holds a muldiv-class instruction; held high while stalled.
- `op_i`  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- `opa_i`  in  WIDTH  rs operand (multiplicand/dividend/MT source).
- `opb_i`  in  WIDTH  rt operand (multiplier/divisor).
- `annul_i`  in  1  flush of the EX instruction (exception/branch squash).
- `stallreq_o`  out  1  combinational stall request to the pipeline controller.
- `ready_o`  out  1  one-cycle pulse: result committed to HI/LO this edge.
- `hi_o`  out  WIDTH  HI register.
- `lo_o`  out  WIDTH  LO register.

## Operation
- Reset: state IDLE, `hi_o`=0, `lo_o`=0, `ready_o`=0, `stallreq_o`=0, and all internal accumulators are cleared. `rst` overrides every other input.
- States: IDLE, MUL, DIV, DONE.
- IDLE, `start_i`=1, `annul_i`=0:
  - MULT/MULTU: latch operands and go to MUL.
  - DIV/DIVU with `opb_i`≠0: latch magnitudes and signs, clear the counter, and go to DIV.
  - DIV/DIVU with `opb_i`=0: load quotient = all ones and remainder = `opa_i`, then go to DONE.
  - MTHI/MTLO: write `hi_o`/`lo_o` at this edge and stay in IDLE. No stall.
  - NONE/reserved: no action.
- MUL: one cycle computes the full 2·WIDTH product into a registered result.
  - MULT is signed × signed; MULTU is unsigned.
  - Next state: DONE.
- DIV: restoring shift-subtract on magnitudes, one quotient bit per cycle, WIDTH cycles. Next state: DONE.
  - DIV: quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
  - Most-negative ÷ −1 wraps: quotient = most-negative, remainder = 0.
- DONE:
  - Write HI = product[2W-1:W] or remainder, and LO = product[W-1:0] or quotient.
  - Pulse `ready_o` and go to IDLE.
  - `start_i` seen in DONE belongs to the completing instruction and is ignored.
- `annul_i`=1 in any state: return to IDLE at the edge. HI/LO unchanged, no `ready_o`.
  - In IDLE, `annul_i` suppresses a same-cycle start, including MTHI/MTLO writes.
- `stallreq_o` = ¬rst ∧ ¬annul_i ∧ ((IDLE ∧ start_i ∧ op∈{MULT,MULTU,DIV,DIVU}) ∨ MUL ∨ DIV).
  - It is low in DONE, so the instruction leaves EX at the DONE edge.
- Reads (MFHI/MFLO) are handled outside; the pipeline forwards from `hi_o`/`lo_o`. A value written at a DONE edge is visible the next cycle.

## Timing
- MULT/MULTU:
  - Cycle 0: IDLE accept, stall=1.
  - Cycle 1: MUL, stall=1.
  - Cycle 2: DONE, stall=0; HI/LO valid at cycle 3.
  - Total: 2 stall cycles.
- DIV/DIVU, nonzero divisor:
  - Cycle 0: accept.
  - Cycles 1..WIDTH: DIV.
  - Cycle WIDTH+1: DONE.
  - Total: WIDTH+1 stall cycles (33 at default).
- DIV/DIVU by zero: accept (stall=1), then DONE. 1 stall cycle.
- MTHI/MTLO: zero stall; the register updates at the accept edge.
- Back-to-back ops: a new op may be accepted in the cycle after DONE. No bubble is imposed beyond that.

## Configuration
- `EX_DIV_EN` defined: divider and DIV state present, as above.
- Not defined: DIV/DIVU are treated as NONE. No stall, HI/LO unchanged, no `ready_o`. DIV state and divider logic are absent.

## Test plan
- MULT -3 × 5 (WIDTH=32) -> stall 2 cycles, `ready_o` pulse, `hi_o`=FFFFFFFF, `lo_o`=FFFFFFF1.
- MULTU FFFFFFFF × FFFFFFFF -> `hi_o`=FFFFFFFE, `lo_o`=00000001.
- DIV -7 / 2 -> stall 33 cycles, `lo_o`=FFFFFFFD, `hi_o`=FFFFFFFF. Also DIV 80000000 / FFFFFFFF -> `lo_o`=80000000, `hi_o`=0.
- DIVU 7 / 0 -> 1 stall cycle, `lo_o`=FFFFFFFF, `hi_o`=00000007.
- Cancellation: DIVU 100/3 with `annul_i` at DIV cycle 10 -> IDLE next cycle, `stallreq_o`=0, HI/LO keep prior values, no `ready_o`. Repeat with `rst` at cycle 10 -> HI/LO=0.
- Moves: MTHI 00001234, then MTLO 0000ABCD on consecutive cycles -> no stall, `hi_o`/`lo_o` updated the cycle after each. With `EX_DIV_EN` undefined, DIV 8/2 -> no stall, HI/LO unchanged.

Source files
------------

// File: rtl/ex_muldiv.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// Define EX_DIV_EN to build the iterative restoring divider and its DIV state.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             annul_i,
  output logic             stallreq_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef EX_DIV_EN
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam int         CNT_W    = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

  state_t           state;
  logic             ready;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_signed;
  logic             long_op;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Operands are sign- or zero-extended to 2*WIDTH so one multiplier serves both forms.
  logic              sext_a;
  logic              sext_b;
  logic signed [2*WIDTH-1:0] mul_a_ext;
  logic signed [2*WIDTH-1:0] mul_b_ext;
  logic signed [2*WIDTH-1:0] product;

  assign sext_a    = mul_signed & mul_a[WIDTH-1];
  assign sext_b    = mul_signed & mul_b[WIDTH-1];
  assign mul_a_ext = {{WIDTH{sext_a}}, mul_a};
  assign mul_b_ext = {{WIDTH{sext_b}}, mul_b};
  assign product   = mul_a_ext * mul_b_ext;

`ifdef EX_DIV_EN
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quot_next;
  logic [WIDTH-1:0] rem_next;
  logic             sdiv;

  // quot starts as the dividend magnitude and is shifted out MSB-first into rem.
  assign shifted   = {rem, quot[WIDTH-1]};
  assign diff      = shifted - {1'b0, dvs};
  assign quot_next = {quot[WIDTH-2:0], ~diff[WIDTH]};
  assign rem_next  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign sdiv      = (op_i == OP_DIV);
`endif

  always_comb begin
    long_op = 1'b0;
    case (op_i)
      OP_MULT, OP_MULTU: long_op = 1'b1;
`ifdef EX_DIV_EN
      OP_DIV, OP_DIVU:   long_op = 1'b1;
`endif
      default:           long_op = 1'b0;
    endcase
  end

  assign stallreq_o = ~rst & ~annul_i &
                      (((state == S_IDLE) & start_i & long_op) |
`ifdef EX_DIV_EN
                       (state == S_DIV) |
`endif
                       (state == S_MUL));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ready      <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      res_hi     <= '0;
      res_lo     <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
`ifdef EX_DIV_EN
      dvs        <= '0;
      quot       <= '0;
      rem        <= '0;
      cnt        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
`endif
    end else begin
      ready <= 1'b0;
      if (annul_i) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i) begin
              case (op_i)
                OP_MULT, OP_MULTU: begin
                  mul_a      <= opa_i;
                  mul_b      <= opb_i;
                  mul_signed <= (op_i == OP_MULT);
                  state      <= S_MUL;
                end
`ifdef EX_DIV_EN
                OP_DIV, OP_DIVU: begin
                  if (opb_i != '0) begin
                    quot  <= cond_neg(opa_i, sdiv & opa_i[WIDTH-1]);
                    dvs   <= cond_neg(opb_i, sdiv & opb_i[WIDTH-1]);
                    rem   <= '0;
                    cnt   <= '0;
                    neg_q <= sdiv & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
                    neg_r <= sdiv & opa_i[WIDTH-1];
                    state <= S_DIV;
                  end else begin
                    res_lo <= '1;
                    res_hi <= opa_i;
                    state  <= S_DONE;
                  end
                end
`endif
                OP_MTHI: hi <= opa_i;
                OP_MTLO: lo <= opa_i;
                default: ;
              endcase
            end
          end
          S_MUL: begin
            res_hi <= product[2*WIDTH-1:WIDTH];
            res_lo <= product[WIDTH-1:0];
            state  <= S_DONE;
          end
`ifdef EX_DIV_EN
          S_DIV: begin
            quot <= quot_next;
            rem  <= rem_next;
            cnt  <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH-1)) begin
              res_lo <= cond_neg(quot_next, neg_q);
              res_hi <= cond_neg(rem_next, neg_r);
              state  <= S_DONE;
            end
          end
`endif
          S_DONE: begin
            hi    <= res_hi;
            lo    <= res_lo;
            ready <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign ready_o = ready;
  assign hi_o    = hi;
  assign lo_o    = lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected HI/LO queued at issue, checked on ready_o.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        annul;
  logic        stallreq;
  logic        ready;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .op_i      (op),
    .opa_i     (opa),
    .opb_i     (opb),
    .annul_i   (annul),
    .stallreq_o(stallreq),
    .ready_o   (ready),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every ready_o pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_ready", {63'd0, ready}, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("ready_hi", {32'd0, hi}, {32'd0, e[63:32]});
        check("ready_lo", {32'd0, lo}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic expect_result(input logic [31:0] h, input logic [31:0] l);
    exp_q.push_back({h, l});
    exp_hi = h;
    exp_lo = l;
  endtask

  // Issue one op (called just after a rising edge) and hold start until stall drops.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int exp_stall, input string name);
    int  n;
    bit  busy;
    start = 1'b1; op = o; opa = a; opb = b;
    n = 0; busy = 1'b1;
    for (int c = 0; c < 100 && busy; c++) begin
      @(negedge clk);
      if (stallreq === 1'b1) n++;
      else busy = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0; op = 3'd0;
    check({name, "_stall"}, 64'(n), 64'(exp_stall));
  endtask

  task automatic check_regs(input string name);
    check({name, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({name, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; op = 3'd1; opa = 32'd3; opb = 32'd4; annul = 1'b0;
    exp_hi = '0; exp_lo = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall", {63'd0, stallreq}, 64'd0);
    check("reset_ready", {63'd0, ready}, 64'd0);
    check_regs("reset");
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; op = 3'd0;

    // Multiplies, issued back to back
    expect_result(32'hFFFFFFFF, 32'hFFFFFFF1);
    do_op(3'd1, 32'hFFFFFFFD, 32'd5, 2, "mult_m3x5");
    expect_result(32'hFFFFFFFE, 32'h00000001);
    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, "multu_max");
    expect_result(32'h00000000, 32'h00000001);
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, "mult_m1xm1");
    expect_result(32'hC0000000, 32'h80000000);
    do_op(3'd1, 32'h7FFFFFFF, 32'h80000000, 2, "mult_maxxmin");
    expect_result(32'h00000001, 32'h23450000);
    do_op(3'd2, 32'h00012345, 32'h00010000, 2, "multu_shift");

    // Moves on consecutive cycles
    exp_hi = 32'h00001234;
    do_op(3'd5, 32'h00001234, 32'd0, 0, "mthi");
    check("mthi_hi", {32'd0, hi}, {32'd0, exp_hi});
    exp_lo = 32'h0000ABCD;
    do_op(3'd6, 32'h0000ABCD, 32'd0, 0, "mtlo");
    check_regs("mtlo");

    // Annul in IDLE suppresses a move
    start = 1'b1; op = 3'd5; opa = 32'hDEADBEEF; annul = 1'b1;
    @(negedge clk);
    check("annul_idle_stall", {63'd0, stallreq}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0; annul = 1'b0;
    check_regs("annul_idle");

    // Annul during MUL
    start = 1'b1; op = 3'd1; opa = 32'd3; opb = 32'd3;
    @(posedge clk); #1;
    annul = 1'b1;
    @(negedge clk);
    check("annul_mul_stall", {63'd0, stallreq}, 64'd0);
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0; op = 3'd0;
    @(negedge clk);
    check("annul_mul_after", {63'd0, stallreq}, 64'd0);
    repeat (3) @(posedge clk); #1;
    check_regs("annul_mul");

`ifdef EX_DIV_EN
    expect_result(32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op(3'd3, 32'hFFFFFFF9, 32'd2, 33, "div_m7d2");
    expect_result(32'h00000000, 32'h80000000);
    do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 33, "div_minxm1");
    expect_result(32'h00000001, 32'hFFFFFFFD);
    do_op(3'd3, 32'd7, 32'hFFFFFFFE, 33, "div_7dm2");
    expect_result(32'h00000007, 32'hFFFFFFFF);
    do_op(3'd4, 32'd7, 32'd0, 1, "divu_by0");
    expect_result(32'h00000001, 32'h00000021);
    do_op(3'd4, 32'd100, 32'd3, 33, "divu_100d3");
    repeat (2) @(posedge clk); #1;

    // Annul at DIV cycle 10
    start = 1'b1; op = 3'd4; opa = 32'd100; opb = 32'd3;
    repeat (10) @(posedge clk); #1;
    annul = 1'b1;
    @(negedge clk);
    check("annul_div_stall", {63'd0, stallreq}, 64'd0);
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0; op = 3'd0;
    @(negedge clk);
    check("annul_div_after", {63'd0, stallreq}, 64'd0);
    repeat (3) @(posedge clk); #1;
    check_regs("annul_div");

    // Reset at DIV cycle 10
    start = 1'b1; op = 3'd4; opa = 32'd100; opb = 32'd3;
    repeat (10) @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_div_stall", {63'd0, stallreq}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; op = 3'd0;
    exp_hi = '0; exp_lo = '0;
    repeat (3) @(posedge clk); #1;
    check_regs("rst_div");
`else
    // Divider compiled out: DIV/DIVU behave as NONE
    do_op(3'd3, 32'd8, 32'd2, 0, "div_absent");
    do_op(3'd4, 32'd8, 32'd0, 0, "divu_absent");
    repeat (3) @(posedge clk); #1;
    check_regs("div_absent");
`endif

    // Reset during MUL clears HI/LO and the pending result
    start = 1'b1; op = 3'd2; opa = 32'd9; opb = 32'd9;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; op = 3'd0;
    exp_hi = '0; exp_lo = '0;
    repeat (3) @(posedge clk); #1;
    check_regs("rst_mul");

    expect_result(32'h00000000, 32'h0000002A);
    do_op(3'd1, 32'd6, 32'd7, 2, "mult_after_rst");
    repeat (3) @(posedge clk); #1;
    check_regs("final");
    check("pending_results", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
